// File: rtl/udp_tx_buf_pkg.sv
// udp_tx_pkg: shared constants, read FSM encoding and saturating index helper for udp_tx_buf.
package udp_tx_pkg;
   localparam int MAX_BYTES_DEF = 1472;
   localparam int MIN_PAYLOAD = 18;
   typedef enum logic [2:0] {IDLE, LOAD, START, SEND, WAIT_DONE} state_t;
   function automatic logic [15:0] sat_inc(input logic [15:0] idx, input logic [15:0] len);
      return (idx + 16'd1 >= len) ? len - 16'd1 : idx + 16'd1;
   endfunction
endpackage

// File: rtl/udp_tx_buf_if.sv
// udp_tx_buf_if: payload write stream plus transmitter handshake of udp_tx_buf.
interface udp_tx_buf_if;
   logic        wr_en;
   logic [7:0]  wr_data;
   logic        wr_last;
   logic [47:0] wr_mac;
   logic        wr_ready;
   logic        tx_start_en;
   logic [15:0] tx_byte_num;
   logic [47:0] des_mac;
   logic        tx_req;
   logic [7:0]  tx_data;
   logic        tx_done;
   logic        drop_pulse;
   modport slave (
      input  wr_en, wr_data, wr_last, wr_mac, tx_req, tx_done,
      output wr_ready, tx_start_en, tx_byte_num, des_mac, tx_data, drop_pulse
   );
   modport master (
      output wr_en, wr_data, wr_last, wr_mac, tx_req, tx_done,
      input  wr_ready, tx_start_en, tx_byte_num, des_mac, tx_data, drop_pulse
   );
endinterface

// File: rtl/udp_tx_buf_ram.sv
// udp_tx_buf_ram: two-bank byte RAM addressed {bank, addr}, one write port and one registered read port.
module udp_tx_buf_ram #(
   parameter int AW = 11
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        we,
   input  logic [AW:0] waddr,
   input  logic [7:0]  wdata,
   input  logic        re,
   input  logic [AW:0] raddr,
   output logic [7:0]  rdata
);
   logic [7:0] mem [2**(AW+1)];
   always_ff @(posedge clk)
      if (we) mem[waddr] <= wdata;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) rdata <= '0;
      else if (re) rdata <= mem[raddr];
endmodule

// File: rtl/udp_tx_buf.sv
// udp_tx_buf: ping-pong payload buffer feeding the UDP/IP/Ethernet transmitter,
// byte stream in, one frame per bank, first-word-fall-through bytes out against tx_req.
module udp_tx_buf
   import udp_tx_pkg::*;
#(
   parameter int MAX_BYTES = MAX_BYTES_DEF,
   parameter int AW = 11
) (
   input logic clk,
   input logic rst_n,
   udp_tx_buf_if.slave bus
);
   state_t      state, state_nxt;
   logic [1:0]  full;
   logic [15:0] len [2];
   logic [47:0] mac [2];
   logic        wb, rb, ovf, rej;
   logic [15:0] wcnt, ridx, ridx_nxt;
   logic        acc, ovf_hit, wr_go, commit, rej_hit, drop_nxt;
   logic        rel, load_go, re;
   logic [AW-1:0] raddr;

   assign bus.wr_ready = !full[wb];
   assign bus.tx_start_en = (state == START);
   assign acc = bus.wr_en & bus.wr_ready & !ovf & !rej;
   assign ovf_hit = acc & (wcnt == 16'(MAX_BYTES));
   assign wr_go = acc & !ovf_hit;
   assign commit = wr_go & bus.wr_last;
   // a frame whose first byte meets a full bank is discarded whole, not truncated
   assign rej_hit = bus.wr_en & !bus.wr_ready & !ovf & !rej;
   assign drop_nxt = rej_hit | (bus.wr_en & bus.wr_last & ovf) | (ovf_hit & bus.wr_last);

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         wb <= 1'b0;
         wcnt <= '0;
         ovf <= 1'b0;
         rej <= 1'b0;
         bus.drop_pulse <= 1'b0;
      end else begin
         bus.drop_pulse <= drop_nxt;
         wcnt <= (commit | ovf_hit) ? '0 : wr_go ? wcnt + 16'd1 : wcnt;
         ovf <= (ovf_hit & !bus.wr_last) | (ovf & !(bus.wr_en & bus.wr_last));
         rej <= (rej_hit & !bus.wr_last) | (rej & !(bus.wr_en & bus.wr_last));
         wb <= commit ? !wb : wb;
      end

   always_ff @(posedge clk)
      if (commit) begin
         len[wb] <= wcnt + 16'd1;
         mac[wb] <= bus.wr_mac;
      end

   always_comb begin
      state_nxt = state;
      ridx_nxt = ridx;
      rel = 1'b0;
      load_go = 1'b0;
      re = 1'b1;
      raddr = ridx[AW-1:0];
      unique case (state)
         IDLE: begin
            load_go = full[rb];
            re = full[rb];
            raddr = '0;
            ridx_nxt = '0;
            state_nxt = full[rb] ? LOAD : IDLE;
         end
         LOAD: state_nxt = START;
         START: state_nxt = SEND;
         SEND: begin
            ridx_nxt = bus.tx_req ? sat_inc(ridx, bus.tx_byte_num) : ridx;
            raddr = ridx_nxt[AW-1:0];
            state_nxt = bus.tx_done ? WAIT_DONE : SEND;
         end
         WAIT_DONE: begin
            rel = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= state_nxt;

   // commit and release touch different banks whenever they coincide
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         full <= '0;
         rb <= 1'b0;
         ridx <= '0;
         bus.tx_byte_num <= '0;
         bus.des_mac <= '0;
      end else begin
         full <= (full | (2'(commit) << wb)) & ~(2'(rel) << rb);
         rb <= rel ? !rb : rb;
         ridx <= ridx_nxt;
         if (load_go) begin
            bus.tx_byte_num <= len[rb];
            bus.des_mac <= mac[rb];
         end
      end

   udp_tx_buf_ram #(.AW(AW)) u_ram (
      .clk(clk),
      .rst_n(rst_n),
      .we(wr_go),
      .waddr({wb, wcnt[AW-1:0]}),
      .wdata(bus.wr_data),
      .re(re),
      .raddr({rb, raddr}),
      .rdata(bus.tx_data)
   );
endmodule
